// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded fields and operands for Execute.
// Priority per edge is rst > flush > freeze > load; control bits are bubbled when valid_in is low.
module id_ex_stage_reg #(
  parameter int REG_LEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               freeze,
  input  logic               valid_in,
  input  logic [REG_LEN-1:0] pc_in,
  input  logic [REG_LEN-1:0] val_rn_in,
  input  logic [REG_LEN-1:0] val_rm_in,
  input  logic [11:0]        shift_operand_in,
  input  logic               immd_in,
  input  logic [23:0]        signed_imm_24_in,
  input  logic [3:0]         exe_cmd_in,
  input  logic               mem_r_en_in,
  input  logic               mem_w_en_in,
  input  logic               wb_en_in,
  input  logic               b_in,
  input  logic               s_in,
  input  logic [3:0]         dest_in,
  input  logic [3:0]         src1_in,
  input  logic [3:0]         src2_in,
  input  logic [3:0]         status_in,
  output logic               valid_out,
  output logic [REG_LEN-1:0] pc_out,
  output logic [REG_LEN-1:0] val_rn_out,
  output logic [REG_LEN-1:0] val_rm_out,
  output logic [11:0]        shift_operand_out,
  output logic               immd_out,
  output logic [23:0]        signed_imm_24_out,
  output logic [3:0]         exe_cmd_out,
  output logic               mem_r_en_out,
  output logic               mem_w_en_out,
  output logic               wb_en_out,
  output logic               b_out,
  output logic               s_out,
  output logic [3:0]         dest_out,
  output logic [3:0]         src1_out,
  output logic [3:0]         src2_out,
  output logic [3:0]         status_out,
  output logic               is_mem_command_out
);

  typedef struct packed {
    logic               valid;
    logic [REG_LEN-1:0] pc;
    logic [REG_LEN-1:0] val_rn;
    logic [REG_LEN-1:0] val_rm;
    logic [11:0]        shift_operand;
    logic               immd;
    logic [23:0]        signed_imm_24;
    logic [3:0]         exe_cmd;
    logic               mem_r_en;
    logic               mem_w_en;
    logic               wb_en;
    logic               b;
    logic               s;
    logic [3:0]         dest;
    logic [3:0]         src1;
    logic [3:0]         src2;
    logic [3:0]         status;
  } stage_t;

  stage_t d, q;

  always_comb begin
    d               = '0;
    d.valid         = valid_in;
    d.pc            = pc_in;
    d.val_rn        = val_rn_in;
    d.val_rm        = val_rm_in;
    d.shift_operand = shift_operand_in;
    d.immd          = immd_in;
    d.signed_imm_24 = signed_imm_24_in;
    d.exe_cmd       = exe_cmd_in;
    // Side-effecting controls only travel with a real instruction
    d.mem_r_en      = mem_r_en_in & valid_in;
    d.mem_w_en      = mem_w_en_in & valid_in;
    d.wb_en         = wb_en_in    & valid_in;
    d.b             = b_in        & valid_in;
    d.s             = s_in        & valid_in;
    d.dest          = dest_in;
    d.src1          = src1_in;
    d.src2          = src2_in;
    d.status        = status_in;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) q <= '0;
    else if (!freeze) q <= d;
  end

  assign valid_out          = q.valid;
  assign pc_out             = q.pc;
  assign val_rn_out         = q.val_rn;
  assign val_rm_out         = q.val_rm;
  assign shift_operand_out  = q.shift_operand;
  assign immd_out           = q.immd;
  assign signed_imm_24_out  = q.signed_imm_24;
  assign exe_cmd_out        = q.exe_cmd;
  assign mem_r_en_out       = q.mem_r_en;
  assign mem_w_en_out       = q.mem_w_en;
  assign wb_en_out          = q.wb_en;
  assign b_out              = q.b;
  assign s_out              = q.s;
  assign dest_out           = q.dest;
  assign src1_out           = q.src1;
  assign src2_out           = q.src2;
  assign status_out         = q.status;
  assign is_mem_command_out = q.mem_r_en | q.mem_w_en;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed cases then a random stream vs a reference model.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rn, rm;
    logic [11:0] sh;
    logic        immd;
    logic [23:0] imm24;
    logic [3:0]  cmd;
    logic        mr, mw, wb, b, s;
    logic [3:0]  dest, src1, src2, status;
  } fields_t;

  logic clk = 1'b0;
  logic rst, flush, freeze, is_mem;
  fields_t din, dout, model;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.REG_LEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .valid_in(din.valid), .pc_in(din.pc), .val_rn_in(din.rn), .val_rm_in(din.rm),
    .shift_operand_in(din.sh), .immd_in(din.immd), .signed_imm_24_in(din.imm24),
    .exe_cmd_in(din.cmd), .mem_r_en_in(din.mr), .mem_w_en_in(din.mw), .wb_en_in(din.wb),
    .b_in(din.b), .s_in(din.s), .dest_in(din.dest), .src1_in(din.src1), .src2_in(din.src2),
    .status_in(din.status),
    .valid_out(dout.valid), .pc_out(dout.pc), .val_rn_out(dout.rn), .val_rm_out(dout.rm),
    .shift_operand_out(dout.sh), .immd_out(dout.immd), .signed_imm_24_out(dout.imm24),
    .exe_cmd_out(dout.cmd), .mem_r_en_out(dout.mr), .mem_w_en_out(dout.mw), .wb_en_out(dout.wb),
    .b_out(dout.b), .s_out(dout.s), .dest_out(dout.dest), .src1_out(dout.src1),
    .src2_out(dout.src2), .status_out(dout.status), .is_mem_command_out(is_mem)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic fields_t rand_fields();
    fields_t f;
    f = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return f;
  endfunction

  // One clock: the model applies the stage rules to the inputs seen at the edge,
  // then every output is compared mid-cycle.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst || flush) model = '0;
    else if (!freeze) begin
      model = din;
      if (!din.valid) {model.mr, model.mw, model.wb, model.b, model.s} = 5'b0;
    end
    @(negedge clk);
    chk({tag, ".all"}, dout, model);
    chk({tag, ".ismem"}, is_mem, model.mr | model.mw);
    if (!dout.valid) chk({tag, ".inv"}, {dout.mr, dout.mw, dout.wb, dout.b, dout.s}, 5'b0);
  endtask

  initial begin
    model = '0;
    rst = 1'b1; flush = 1'b0; freeze = 1'b0;
    din = rand_fields();
    @(negedge clk);

    // 1: reset with random inputs
    step("rst0"); din = rand_fields();
    step("rst1");
    chk("rst.valid", dout.valid, 1'b0);

    // 2: plain load
    rst = 1'b0;
    din = '0; din.valid = 1'b1; din.pc = 32'h10; din.rm = 32'hF000000F;
    din.sh = 12'h3A5; din.wb = 1'b1; din.dest = 4'h3;
    step("load");
    chk("load.pc", dout.pc, 32'h10);
    chk("load.rm", dout.rm, 32'hF000000F);
    chk("load.sh", dout.sh, 12'h3A5);
    chk("load.wb_dest", {dout.wb, dout.dest}, 5'h13);
    chk("load.ismem", is_mem, 1'b0);

    // 3: freeze holds, release loads
    freeze = 1'b1; din.pc = 32'h20; din.mr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("frz");
      chk("frz.pc", dout.pc, 32'h10);
    end
    freeze = 1'b0;
    step("rel");
    chk("rel.pc", dout.pc, 32'h20);
    chk("rel.ismem", is_mem, 1'b1);

    // 4: flush beats freeze on a loaded store
    din = rand_fields(); din.valid = 1'b1; din.mw = 1'b1;
    step("store");
    chk("store.mw", dout.mw, 1'b1);
    freeze = 1'b1; flush = 1'b1;
    step("fl");
    chk("fl.mw_valid", {dout.mw, dout.valid}, 2'b00);
    chk("fl.zero", dout, 0);
    freeze = 1'b0; flush = 1'b0;

    // 5: invalid instruction bubbles its controls but keeps datapath fields
    din = rand_fields(); din.valid = 1'b0; din.wb = 1'b1; din.b = 1'b1; din.cmd = 4'h9;
    step("bub");
    chk("bub.wb_b", {dout.wb, dout.b}, 2'b00);
    chk("bub.cmd", dout.cmd, 4'h9);
    chk("bub.valid", dout.valid, 1'b0);

    // 6: random stream
    for (int i = 0; i < 1000; i++) begin
      din    = rand_fields();
      rst    = ($urandom_range(0, 49) == 0);
      flush  = ($urandom_range(0, 9) == 0);
      freeze = ($urandom_range(0, 3) == 0);
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
